// File: rtl/csr_regfile_pkg.sv
// Shared CSR address map, widths and the pending-write entry
// used by the CSR register file and its counters.
package csr_regfile_pkg;

  localparam int CSR_WIDTH     = 64;
  localparam int CSR_WIDTH_LOG = 12;

  localparam logic [CSR_WIDTH_LOG-1:0] CSR_FFLAGS   = 12'h001;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_FRM      = 12'h002;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_FCSR     = 12'h003;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_CYCLE    = 12'hC00;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_TIME     = 12'hC01;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_INSTRET  = 12'hC02;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_MSCRATCH = 12'h340;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_MEPC     = 12'h341;

  typedef struct packed {
    logic                     valid;
    logic [CSR_WIDTH_LOG-1:0] addr;
    logic [CSR_WIDTH-1:0]     data;
  } csr_pend_t;

endpackage

// File: rtl/csr_counter.sv
// Free-running wrapping counter with a load port that
// overrides the increment in the same cycle.
module csr_counter #(
  parameter int W  = 64,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic [W-1:0]  ld_val,
  input  logic [IW-1:0] inc,
  output logic [W-1:0]  cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  cnt <= '0;
    else if (ld) cnt <= ld_val;
    else         cnt <= cnt + W'(inc);
  end

endmodule

// File: rtl/csr_regfile.sv
// CSR register file: one-entry speculative write buffer applied
// at commit, FP flag accumulation and cycle/instret counters.
module csr_regfile #(
  parameter int CSR_WIDTH     = csr_regfile_pkg::CSR_WIDTH,
  parameter int CSR_WIDTH_LOG = csr_regfile_pkg::CSR_WIDTH_LOG,
  parameter int COMMIT_WIDTH  = 4,
  localparam int CW = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     csrWrEn_i,
  input  logic [CSR_WIDTH_LOG-1:0] csrWrAddr_i,
  input  logic [CSR_WIDTH-1:0]     csrWrData_i,
  output logic                     csrWrReady_o,
  input  logic                     csrCommit_i,
  input  logic                     flush_i,
  input  logic [CW-1:0]            commitCnt_i,
  input  logic                     fpFlagsValid_i,
  input  logic [4:0]               fpFlags_i,
  input  logic [CSR_WIDTH_LOG-1:0] csrRdAddr_i,
  output logic [CSR_WIDTH-1:0]     csrRdData_o,
  output logic                     csrRdIllegal_o,
  output logic [2:0]               frm_o,
  output logic                     pendingValid_o
);

  import csr_regfile_pkg::*;

  csr_pend_t            pend;
  logic                 wr_acc;
  logic                 cmt;
  logic                 ld_cycle;
  logic                 ld_instret;
  logic [4:0]           fflags;
  logic [2:0]           frm;
  logic [CSR_WIDTH-1:0] mscratch;
  logic [CSR_WIDTH-1:0] mepc;
  logic [CSR_WIDTH-1:0] cycle;
  logic [CSR_WIDTH-1:0] instret;

  assign csrWrReady_o   = !pend.valid;
  assign pendingValid_o = pend.valid;
  assign frm_o          = frm;

  assign wr_acc = csrWrEn_i && !pend.valid && !flush_i;
  assign cmt    = csrCommit_i && pend.valid;

  assign ld_cycle = cmt &&
    (pend.addr == CSR_CYCLE || pend.addr == CSR_TIME);
  assign ld_instret = cmt && (pend.addr == CSR_INSTRET);

  // Commit takes priority over flush: the entry is applied, then freed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
    end else if (cmt || flush_i) begin
      pend.valid <= 1'b0;
    end else if (wr_acc) begin
      pend.valid <= 1'b1;
      pend.addr  <= csrWrAddr_i;
      pend.data  <= csrWrData_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fflags   <= '0;
      frm      <= '0;
      mscratch <= '0;
      mepc     <= '0;
    end else begin
      if (cmt && (pend.addr == CSR_FFLAGS ||
                  pend.addr == CSR_FCSR))
        fflags <= pend.data[4:0];
      else if (fpFlagsValid_i)
        fflags <= fflags | fpFlags_i;
      if (cmt && pend.addr == CSR_FRM)
        frm <= pend.data[2:0];
      else if (cmt && pend.addr == CSR_FCSR)
        frm <= pend.data[7:5];
      if (cmt && pend.addr == CSR_MSCRATCH)
        mscratch <= pend.data;
      if (cmt && pend.addr == CSR_MEPC)
        mepc <= pend.data;
    end
  end

  csr_counter #(.W(CSR_WIDTH), .IW(CW)) u_cycle (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld_cycle),
    .ld_val (pend.data),
    .inc    (CW'(1)),
    .cnt    (cycle)
  );

  csr_counter #(.W(CSR_WIDTH), .IW(CW)) u_instret (
    .clk    (clk),
    .reset  (reset),
    .ld     (ld_instret),
    .ld_val (pend.data),
    .inc    (commitCnt_i),
    .cnt    (instret)
  );

  always_comb begin
    csrRdData_o    = '0;
    csrRdIllegal_o = 1'b0;
    unique case (csrRdAddr_i)
      CSR_FFLAGS:          csrRdData_o = CSR_WIDTH'(fflags);
      CSR_FRM:             csrRdData_o = CSR_WIDTH'(frm);
      CSR_FCSR:            csrRdData_o = CSR_WIDTH'({frm, fflags});
      CSR_CYCLE, CSR_TIME: csrRdData_o = cycle;
      CSR_INSTRET:         csrRdData_o = instret;
      CSR_MSCRATCH:        csrRdData_o = mscratch;
      CSR_MEPC:            csrRdData_o = mepc;
      default:             csrRdIllegal_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed and random checks of csr_regfile against a
// behavioural model of the CSR state.
module tb_csr_regfile;

  logic        clk;
  logic        reset;
  logic        csrWrEn_i;
  logic [11:0] csrWrAddr_i;
  logic [63:0] csrWrData_i;
  logic        csrWrReady_o;
  logic        csrCommit_i;
  logic        flush_i;
  logic [2:0]  commitCnt_i;
  logic        fpFlagsValid_i;
  logic [4:0]  fpFlags_i;
  logic [11:0] csrRdAddr_i;
  logic [63:0] csrRdData_o;
  logic        csrRdIllegal_o;
  logic [2:0]  frm_o;
  logic        pendingValid_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] m_cycle, m_instret, m_mscratch, m_mepc;
  logic [4:0]  m_fflags;
  logic [2:0]  m_frm;
  logic        p_valid;
  logic [11:0] p_addr;
  logic [63:0] p_data;

  logic [11:0] addrs [9] = '{12'h001, 12'h002, 12'h003,
    12'hC00, 12'hC01, 12'hC02, 12'h340, 12'h341, 12'h7FF};

  csr_regfile dut (
    .clk            (clk),
    .reset          (reset),
    .csrWrEn_i      (csrWrEn_i),
    .csrWrAddr_i    (csrWrAddr_i),
    .csrWrData_i    (csrWrData_i),
    .csrWrReady_o   (csrWrReady_o),
    .csrCommit_i    (csrCommit_i),
    .flush_i        (flush_i),
    .commitCnt_i    (commitCnt_i),
    .fpFlagsValid_i (fpFlagsValid_i),
    .fpFlags_i      (fpFlags_i),
    .csrRdAddr_i    (csrRdAddr_i),
    .csrRdData_o    (csrRdData_o),
    .csrRdIllegal_o (csrRdIllegal_o),
    .frm_o          (frm_o),
    .pendingValid_o (pendingValid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] mread(input logic [11:0] a);
    case (a)
      12'h001: return {1'b0, 64'(m_fflags)};
      12'h002: return {1'b0, 64'(m_frm)};
      12'h003: return {1'b0, 56'd0, m_frm, m_fflags};
      12'hC00, 12'hC01: return {1'b0, m_cycle};
      12'hC02: return {1'b0, m_instret};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  task automatic model_clear();
    m_cycle = '0; m_instret = '0; m_mscratch = '0; m_mepc = '0;
    m_fflags = '0; m_frm = '0;
    p_valid = 1'b0; p_addr = '0; p_data = '0;
  endtask

  task automatic model_edge();
    logic do_c, acc;
    do_c = csrCommit_i && p_valid;
    acc  = csrWrEn_i && !p_valid && !flush_i;
    m_cycle   = m_cycle + 64'd1;
    m_instret = m_instret + 64'(commitCnt_i);
    if (fpFlagsValid_i) m_fflags = m_fflags | fpFlags_i;
    if (do_c) begin
      case (p_addr)
        12'h001: m_fflags = p_data[4:0];
        12'h002: m_frm = p_data[2:0];
        12'h003: begin
          m_frm = p_data[7:5];
          m_fflags = p_data[4:0];
        end
        12'hC00, 12'hC01: m_cycle = p_data;
        12'hC02: m_instret = p_data;
        12'h340: m_mscratch = p_data;
        12'h341: m_mepc = p_data;
        default: ;
      endcase
    end
    if (do_c || flush_i) begin
      p_valid = 1'b0;
    end else if (acc) begin
      p_valid = 1'b1;
      p_addr = csrWrAddr_i;
      p_data = csrWrData_i;
    end
  endtask

  task automatic check_all();
    logic [64:0] r;
    r = mread(csrRdAddr_i);
    chk("ready", 64'(csrWrReady_o), 64'(!p_valid));
    chk("pending", 64'(pendingValid_o), 64'(p_valid));
    chk("frm_o", 64'(frm_o), 64'(m_frm));
    chk("rd_data", csrRdData_o, r[63:0]);
    chk("rd_illegal", 64'(csrRdIllegal_o), 64'(r[64]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    csrWrEn_i = 1'b0; csrWrAddr_i = '0; csrWrData_i = '0;
    csrCommit_i = 1'b0; flush_i = 1'b0; commitCnt_i = '0;
    fpFlagsValid_i = 1'b0; fpFlags_i = '0;
  endtask

  task automatic wr(logic [11:0] a, logic [63:0] d);
    idle();
    csrWrEn_i = 1'b1; csrWrAddr_i = a; csrWrData_i = d;
  endtask

  task automatic peek(string tag, logic [11:0] a, logic [63:0] exp);
    csrRdAddr_i = a;
    #1;
    chk(tag, csrRdData_o, exp);
  endtask

  initial begin
    idle();
    csrRdAddr_i = '0;
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", 64'(csrWrReady_o), 64'd1);
    chk("rst_pending", 64'(pendingValid_o), 64'd0);
    chk("rst_frm", 64'(frm_o), 64'd0);
    for (int i = 0; i < 8; i++) peek("rst_rd", addrs[i], 64'd0);

    @(negedge clk);
    reset = 1'b1;
    csrRdAddr_i = 12'hC00;
    repeat (10) tick();
    peek("cycle10", 12'hC00, 64'd10);
    peek("instret0", 12'hC02, 64'd0);
    chk("ready_idle", 64'(csrWrReady_o), 64'd1);

    csrRdAddr_i = 12'h340;
    wr(12'h340, 64'hDEAD); tick();
    chk("pend_set", 64'(pendingValid_o), 64'd1);
    idle(); tick();
    chk("mscratch_pre", csrRdData_o, 64'd0);
    csrCommit_i = 1'b1; tick();
    peek("mscratch", 12'h340, 64'hDEAD);
    chk("pend_clr", 64'(pendingValid_o), 64'd0);

    csrRdAddr_i = 12'h341;
    wr(12'h341, 64'h1234); tick();
    idle(); flush_i = 1'b1; tick();
    peek("mepc_flush", 12'h341, 64'd0);
    wr(12'h341, 64'h1234); tick();
    idle(); flush_i = 1'b1; csrCommit_i = 1'b1; tick();
    peek("mepc_fl_cmt", 12'h341, 64'h1234);

    wr(12'h340, 64'h1111); tick();
    wr(12'h340, 64'h2222);
    #1;
    chk("full_ready", 64'(csrWrReady_o), 64'd0);
    tick();
    idle(); csrCommit_i = 1'b1; tick();
    peek("no_capture", 12'h340, 64'h1111);

    wr(12'h001, 64'h01); tick();
    idle(); csrCommit_i = 1'b1; tick();
    idle(); fpFlagsValid_i = 1'b1; fpFlags_i = 5'h04; tick();
    peek("fflags_or", 12'h001, 64'h05);
    wr(12'h003, 64'hE3); tick();
    idle(); csrCommit_i = 1'b1;
    fpFlagsValid_i = 1'b1; fpFlags_i = 5'h10; tick();
    chk("fcsr_frm", 64'(frm_o), 64'd7);
    peek("fcsr_fflags", 12'h001, 64'h03);

    wr(12'hC02, 64'hFFFF_FFFF_FFFF_FFFE); tick();
    idle(); csrCommit_i = 1'b1; commitCnt_i = 3'd3; tick();
    peek("instret_ld", 12'hC02, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(); commitCnt_i = 3'd4; tick();
    peek("instret_wrap", 12'hC02, 64'd2);
    peek("illegal_data", 12'h7FF, 64'd0);
    chk("illegal_flag", 64'(csrRdIllegal_o), 64'd1);

    for (int i = 0; i < 400; i++) begin
      idle();
      csrWrEn_i      = $urandom_range(0, 1) == 1;
      csrWrAddr_i    = addrs[$urandom_range(0, 8)];
      csrWrData_i    = {$urandom, $urandom};
      csrCommit_i    = $urandom_range(0, 2) == 0;
      flush_i        = $urandom_range(0, 7) == 0;
      commitCnt_i    = 3'($urandom_range(0, 4));
      fpFlagsValid_i = $urandom_range(0, 1) == 1;
      fpFlags_i      = 5'($urandom);
      csrRdAddr_i    = addrs[$urandom_range(0, 8)];
      tick();
    end

    idle();
    wr(12'h340, 64'h55); tick();
    idle();
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    chk("async_ready", 64'(csrWrReady_o), 64'd1);
    chk("async_pending", 64'(pendingValid_o), 64'd0);
    peek("async_cycle", 12'hC00, 64'd0);
    peek("async_mscratch", 12'h340, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
